// File: rtl/tlcd_bus_receiver_if.sv
// Text LCD bus as seen on the wire: D7..D0, E, RS, RW.
interface tlcd_bus_receiver_if;
    // Strobe-qualified bus with no backpressure: D/RS/RW are sampled while E is high and
    // the transfer commits on E's falling edge; the receiver never stalls the sender,
    // it only reports busy and flags edges it had to drop.
    logic [7:0] tlcd_d;
    logic       tlcd_e;
    logic       tlcd_rs;
    logic       tlcd_rw;

    modport master (output tlcd_d, output tlcd_e, output tlcd_rs, output tlcd_rw);
    modport slave  (input  tlcd_d, input  tlcd_e, input  tlcd_rs, input  tlcd_rw);
endinterface

// File: rtl/tlcd_bus_receiver.sv
// Receive side of the HD44780-style text LCD bus: decodes write cycles into a 2x16
// character image packed like the display driver's line1/line2 (char 0 in the top byte).
module tlcd_bus_receiver #(
    parameter int SYNC_STAGES  = 2,
    parameter int CLEAR_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    tlcd_bus_receiver_if.slave        bus,
    output logic [127:0]              line1_o,
    output logic [127:0]              line2_o,
    output logic                      display_on_o,
    output logic                      busy_o,
    output logic                      wr_strobe_o,
    output logic                      cmd_strobe_o,
    output logic [7:0]                last_cmd_o,
    output logic                      frame_done_o,
    output logic                      err_overrun_o,
    output logic                      err_read_o,
    output logic                      state_dbg_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    localparam int CW_RAW = $clog2(CLEAR_CYCLES + 1);
    localparam int CW     = (CW_RAW > 6) ? CW_RAW : 6;

    // {d[7:0], rs, rw, e}
    logic [10:0]   sync_q [SYNC_STAGES];
    logic [10:0]   sync_last;
    logic          e_now;
    logic          e_last_q;
    logic          fall;
    logic [9:0]    cap_q;
    logic [7:0]    bus_data;
    logic          bus_rs;
    logic          bus_rw;

    state_e        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]    cells_q [32];
    logic [7:0]    cells_d [32];
    logic [6:0]    ac_q, ac_d;
    logic          id_q, id_d;
    logic          disp_q, disp_d;
    logic          cgram_q, cgram_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic          wr_stb_q, wr_stb_d;
    logic          cmd_stb_q, cmd_stb_d;
    logic          frame_q, frame_d;
    logic          err_ovr_q, err_ovr_d;
    logic          err_rd_q, err_rd_d;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic ddram_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.tlcd_d, bus.tlcd_rs, bus.tlcd_rw, bus.tlcd_e};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign e_now     = sync_last[0];
    assign fall      = e_last_q & ~e_now;
    assign bus_data  = cap_q[9:2];
    assign bus_rs    = cap_q[1];
    assign bus_rw    = cap_q[0];

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        cells_d    = cells_q;
        ac_d       = ac_q;
        id_d       = id_q;
        disp_d     = disp_q;
        cgram_d    = cgram_q;
        last_cmd_d = last_cmd_q;
        err_ovr_d  = err_ovr_q;
        err_rd_d   = err_rd_q;
        wr_stb_d   = 1'b0;
        cmd_stb_d  = 1'b0;
        frame_d    = 1'b0;

        // Fill one cell per cycle; cells 0..15 are line1, 16..31 are line2.
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q < CW'(32)) cells_d[clr_cnt_q[4:0]] = 8'h20;
            if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + CW'(1);
            end
        end

        if (fall) begin
            if (bus_rw) err_rd_d = 1'b1;
            if (state_q == ST_CLEAR) begin
                err_ovr_d = 1'b1;
            end else if (!bus_rw && !bus_rs) begin
                casez (bus_data)
                    8'b1???????: begin
                        ac_d    = ddram_valid(bus_data[6:0]) ? bus_data[6:0] : 7'h00;
                        cgram_d = 1'b0;
                    end
                    8'b01??????: cgram_d = 1'b1;
                    8'b001?????: begin end
                    8'b0001????: if (!bus_data[3]) ac_d = ac_step(ac_q, bus_data[2]);
                    8'b00001???: disp_d = bus_data[2];
                    8'b000001??: id_d = bus_data[1];
                    8'b0000001?: ac_d = 7'h00;
                    8'b00000001: begin
                        ac_d      = 7'h00;
                        id_d      = 1'b1;
                        state_d   = ST_CLEAR;
                        clr_cnt_d = '0;
                    end
                    default: begin end
                endcase
                if (bus_data != 8'h00) begin
                    cmd_stb_d  = 1'b1;
                    last_cmd_d = bus_data;
                end
            end else if (!bus_rw && !cgram_q) begin
                if (ac_q <= 7'h0F) begin
                    cells_d[{1'b0, ac_q[3:0]}] = bus_data;
                    wr_stb_d = 1'b1;
                end else if ((ac_q >= 7'h40) && (ac_q <= 7'h4F)) begin
                    cells_d[{1'b1, ac_q[3:0]}] = bus_data;
                    wr_stb_d = 1'b1;
                    frame_d  = (ac_q == 7'h4F);
                end
                ac_d = ac_step(ac_q, id_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_last_q   <= 1'b0;
            cap_q      <= '0;
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            for (int i = 0; i < 32; i++) cells_q[i] <= 8'h20;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            cgram_q    <= 1'b0;
            last_cmd_q <= 8'h00;
            wr_stb_q   <= 1'b0;
            cmd_stb_q  <= 1'b0;
            frame_q    <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            e_last_q   <= e_now;
            if (e_now) cap_q <= sync_last[10:1];
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            cells_q    <= cells_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            cgram_q    <= cgram_d;
            last_cmd_q <= last_cmd_d;
            wr_stb_q   <= wr_stb_d;
            cmd_stb_q  <= cmd_stb_d;
            frame_q    <= frame_d;
            err_ovr_q  <= err_ovr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    always_comb begin
        line1_o = '0;
        line2_o = '0;
        for (int i = 0; i < 16; i++) begin
            line1_o[127-8*i -: 8] = cells_q[i];
            line2_o[127-8*i -: 8] = cells_q[16+i];
        end
    end

    assign display_on_o  = disp_q;
    assign busy_o        = (state_q == ST_CLEAR);
    assign wr_strobe_o   = wr_stb_q;
    assign cmd_strobe_o  = cmd_stb_q;
    assign last_cmd_o    = last_cmd_q;
    assign frame_done_o  = frame_q;
    assign err_overrun_o = err_ovr_q;
    assign err_read_o    = err_rd_q;
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_tlcd_bus_receiver.sv
// Bench for tlcd_bus_receiver: directed LCD sequences plus random bus traffic, checked
// against an address-list model of the DDRAM and a strobe-driven scoreboard.
module tb_tlcd_bus_receiver;
    localparam int CLEAR_CYCLES = 32;
    localparam int WQ = 14;  // {frame, cell[4:0], data[7:0]}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] line1_o, line2_o;
    logic         display_on_o, busy_o, wr_strobe_o, cmd_strobe_o, frame_done_o;
    logic         err_overrun_o, err_read_o, state_dbg_o;
    logic [7:0]   last_cmd_o;

    always #5 clk = ~clk;

    tlcd_bus_receiver_if bus();

    tlcd_bus_receiver #(.SYNC_STAGES(2), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .line1_o(line1_o), .line2_o(line2_o), .display_on_o(display_on_o), .busy_o(busy_o),
        .wr_strobe_o(wr_strobe_o), .cmd_strobe_o(cmd_strobe_o), .last_cmd_o(last_cmd_o),
        .frame_done_o(frame_done_o), .err_overrun_o(err_overrun_o), .err_read_o(err_read_o),
        .state_dbg_o(state_dbg_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: AC is a position in the ordered list of the 80 DDRAM addresses.
    logic [7:0] m_scr [32];
    int         m_pos;
    logic       m_id, m_disp, m_cgram, m_err_ovr, m_err_rd;
    logic [7:0] m_last_cmd;
    int         m_wr_cnt = 0;
    int         m_frame_cnt = 0;

    logic [WQ-1:0] exp_q [$];
    logic [7:0]    exp_cmd_q [$];

    int wr_seen = 0;
    int frame_seen = 0;
    int busy_run = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int addr_to_pos(input int a);
        if (a < 40) return a;
        if (a >= 64 && a < 104) return a - 24;
        return 0;
    endfunction

    function automatic int pos_to_addr(input int p);
        return (p < 40) ? p : p + 24;
    endfunction

    function automatic int pos_move(input int p, input logic up);
        return (p + (up ? 1 : 79)) % 80;
    endfunction

    function automatic logic [127:0] model_line(input int row);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m_scr[row*16+i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
        m_pos = 0; m_id = 1'b1; m_disp = 1'b0; m_cgram = 1'b0;
        m_err_ovr = 1'b0; m_err_rd = 1'b0; m_last_cmd = 8'h00;
    endtask

    task automatic model_cmd(input logic [7:0] d);
        if (d[7]) begin
            m_pos = addr_to_pos(int'(d[6:0]));
            m_cgram = 1'b0;
        end else if (d[6]) m_cgram = 1'b1;
        else if (d[5]) begin end
        else if (d[4]) begin
            if (!d[3]) m_pos = pos_move(m_pos, d[2]);
        end else if (d[3]) m_disp = d[2];
        else if (d[2]) m_id = d[1];
        else if (d[1]) m_pos = 0;
        else if (d[0]) begin
            m_pos = 0; m_id = 1'b1;
            for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
        end
        if (d != 8'h00) begin
            exp_cmd_q.push_back(d);
            m_last_cmd = d;
        end
    endtask

    task automatic model_data(input logic [7:0] d);
        int a, idx;
        logic fr;
        if (!m_cgram) begin
            a = pos_to_addr(m_pos);
            if (a < 16) idx = a;
            else if (a >= 64 && a < 80) idx = a - 48;
            else idx = -1;
            if (idx >= 0) begin
                fr = (a == 79);
                m_scr[idx] = d;
                exp_q.push_back({fr, idx[4:0], d});
                m_wr_cnt++;
                if (fr) m_frame_cnt++;
            end
            m_pos = pos_move(m_pos, m_id);
        end
    endtask

    task automatic bus_edge(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.tlcd_d = d; bus.tlcd_rs = rs; bus.tlcd_rw = rw; bus.tlcd_e = 1'b1;
        repeat (3) @(negedge clk);
        bus.tlcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", busy_o, 1'b0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        if (rs) model_data(d); else model_cmd(d);
        bus_edge(rs, 1'b0, d);
        if (!rs && d == 8'h01) wait_idle();
    endtask

    task automatic check_all(input string tag);
        check({tag, "_line1"}, line1_o, model_line(0));
        check({tag, "_line2"}, line2_o, model_line(1));
        check({tag, "_display_on"}, display_on_o, m_disp);
        check({tag, "_err_overrun"}, err_overrun_o, m_err_ovr);
        check({tag, "_err_read"}, err_read_o, m_err_rd);
        check({tag, "_last_cmd"}, last_cmd_o, m_last_cmd);
        check({tag, "_busy"}, busy_o, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses a strobe.
    always @(negedge clk) begin
        logic [WQ-1:0] e;
        logic [7:0]    c;
        int            idx;
        if (rst) begin
            busy_run  = 0;
            busy_prev = 1'b0;
        end else begin
            if (wr_strobe_o) begin
                wr_seen++;
                if (exp_q.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    idx = int'(e[12:8]);
                    if (idx < 16) c = line1_o[127-8*idx -: 8];
                    else c = line2_o[127-8*(idx-16) -: 8];
                    check("wr_cell", c, e[7:0]);
                    check("wr_frame_done", frame_done_o, e[13]);
                end
            end else if (frame_done_o) check("frame_without_write", 1'b1, 1'b0);
            if (frame_done_o) frame_seen++;
            if (cmd_strobe_o) begin
                if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1'b1, 1'b0);
                else check("cmd_byte", last_cmd_o, exp_cmd_q.pop_front());
            end
            if (busy_o) busy_run++;
            else begin
                if (busy_prev) check("busy_length", busy_run, CLEAR_CYCLES);
                busy_run = 0;
            end
            busy_prev = busy_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] roul;
        int w0, f0;
        bus.tlcd_d = 8'h00; bus.tlcd_e = 1'b0; bus.tlcd_rs = 1'b0; bus.tlcd_rw = 1'b0;
        model_reset();

        // T1 reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_line1", line1_o, {16{8'h20}});
        check("t1_line2", line2_o, {16{8'h20}});
        check("t1_flags", {display_on_o, busy_o, wr_strobe_o, cmd_strobe_o, frame_done_o,
                           err_overrun_o, err_read_o}, 7'b0);
        check("t1_last_cmd", last_cmd_o, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T2 init + text
        w0 = wr_seen;
        send(0, 8'h38); send(0, 8'h0C); send(0, 8'h06); send(0, 8'h01);
        send(0, 8'h80);
        roul = "ROULETTE";
        for (int i = 0; i < 8; i++) send(1, roul[63-8*i -: 8]);
        check("t2_text", line1_o[127:64], roul);
        check("t2_display_on", display_on_o, 1'b1);
        check("t2_wr_pulses", wr_seen - w0, 8);
        check("t2_last_cmd", last_cmd_o, 8'h80);
        check_all("t2");

        // T3 line2 fill with one overflow byte
        w0 = wr_seen; f0 = frame_seen;
        send(0, 8'hC0);
        for (int i = 0; i < 17; i++) send(1, 8'($urandom_range(33, 126)));
        check("t3_wr_pulses", wr_seen - w0, 16);
        check("t3_frame_pulses", frame_seen - f0, 1);
        check_all("t3");

        // T4 address wrap both directions
        send(0, 8'hA7); send(1, "A"); send(1, "B");
        check("t4_line2_c0", line2_o[127:120], 8'h42);
        send(0, 8'h04); send(0, 8'h80); send(1, "X"); send(1, "Y");
        check("t4_line1_c0", line1_o[127:120], 8'h58);
        check_all("t4");

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            int sel;
            logic [7:0] r;
            sel = $urandom_range(0, 15);
            r = 8'($urandom_range(0, 255));
            case (sel)
                6:  send(0, {1'b1, r[6:0]});
                7:  send(0, {2'b01, r[5:0]});
                8:  send(0, {3'b001, r[4:0]});
                9:  send(0, {4'b0001, r[3:0]});
                10: send(0, {5'b00001, r[2:0]});
                11: send(0, {6'b000001, r[1:0]});
                12: send(0, {7'b0000001, r[0]});
                13: send(0, 8'h00);
                14: send(0, 8'h01);
                15: send(0, {1'b1, r[7], 2'b00, r[3:0]});
                default: send(1, 8'($urandom_range(32, 126)));
            endcase
            if (k % 50 == 49) check_all("rand");
        end

        // T5 overrun during clear
        model_cmd(8'h01);
        bus_edge(0, 1'b0, 8'h01);
        m_err_ovr = 1'b1;
        bus_edge(1, 1'b0, 8'h51);
        wait_idle();
        check("t5_err_overrun", err_overrun_o, 1'b1);
        check("t5_line1", line1_o, {16{8'h20}});
        check("t5_line2", line2_o, {16{8'h20}});
        check_all("t5");

        // T6 reset mid-clear, then a read cycle
        send(0, 8'h80); send(1, "Q");
        model_cmd(8'h01);
        bus_edge(0, 1'b0, 8'h01);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_busy_after_rst", busy_o, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("t6_rst");
        send(1, "H"); send(1, "I");
        m_err_rd = 1'b1;
        bus_edge(1, 1'b1, 8'h5A);
        check("t6_err_read", err_read_o, 1'b1);
        check_all("t6_read");

        repeat (4) @(negedge clk);
        check("wr_queue_empty", exp_q.size(), 0);
        check("cmd_queue_empty", exp_cmd_q.size(), 0);
        check("wr_total", wr_seen, m_wr_cnt);
        check("frame_total", frame_seen, m_frame_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
